// File: rtl/voice_num_sequencer.sv
// Number announcer: converts a binary reading to decimal (iterative double-dabble)
// and streams the voice-segment codes that speak it over a valid/ready handshake.
module voice_num_sequencer #(
  parameter int                VAL_W        = 10,
  parameter int                MAX_DIG      = 3,
  parameter int                CODE_W       = 5,
  parameter logic [CODE_W-1:0] ZERO_CODE    = 5'b11110,
  parameter logic [CODE_W-1:0] NONE_CODE    = 5'b01000,
  parameter logic [CODE_W-1:0] HUNDRED_CODE = 5'b00111,
  parameter int                ONES_BASE    = 30,
  parameter int                TENS_BASE    = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [VAL_W-1:0]  value,
  output logic              busy,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              done
);

  localparam int          BCD_W   = (MAX_DIG + 1) * 4;
  localparam int          CNT_W   = $clog2(VAL_W + 1);
  localparam logic [31:0] MAX_VAL = 32'(10 ** MAX_DIG - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  if (MAX_DIG < 2 || MAX_DIG > 3) begin : gDigCheck
    $error("voice_num_sequencer: MAX_DIG must be 2 or 3");
  end
  if (VAL_W < 31 && ((1 << VAL_W) - 1) < (10 ** MAX_DIG - 1)) begin : gWidthCheck
    $error("voice_num_sequencer: VAL_W too narrow for 10^MAX_DIG-1");
  end

  function automatic logic [CODE_W-1:0] onesCode(input logic [3:0] d);
    return CODE_W'(ONES_BASE - int'(d));
  endfunction

  function automatic logic [CODE_W-1:0] tensCode(input logic [3:0] d);
    return CODE_W'(TENS_BASE - int'(d));
  endfunction

  logic [1:0]        state_q, state_d;
  logic [VAL_W-1:0]  shift_q, shift_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic              oor_q, oor_d;
  logic [CODE_W-1:0] seg_q [4];
  logic [CODE_W-1:0] seg_d [4];
  logic [2:0]        segLen_q, segLen_d;
  logic [1:0]        idx_q, idx_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              codeValid_q, codeValid_d;

  logic [BCD_W-1:0]  bcdAdj;
  logic [BCD_W-1:0]  bcdShift;
  logic [3:0]        hunD, tensD, onesD;
  logic              oorAll;
  logic [CODE_W-1:0] segNext [4];
  logic [2:0]        segCnt;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next value bit.
  always_comb begin
    bcdAdj = bcd_q;
    for (int i = 0; i < MAX_DIG + 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcdAdj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign bcdShift = {bcdAdj[BCD_W-2:0], shift_q[VAL_W-1]};
  assign onesD    = bcdShift[3:0];
  assign tensD    = bcdShift[7:4];
  assign hunD     = (MAX_DIG >= 3) ? bcdShift[11:8] : 4'd0;
  // A carry out of the overflow digit or a nonzero overflow digit also means out of range.
  assign oorAll   = oor_q || bcdAdj[BCD_W-1] || (bcdShift[BCD_W-1 -: 4] != 4'd0);

  always_comb begin
    segNext = '{default: NONE_CODE};
    segCnt  = 3'd0;
    if (oorAll) begin
      segNext[0] = NONE_CODE;
      segCnt     = 3'd1;
    end else if (hunD == 4'd0 && tensD == 4'd0 && onesD == 4'd0) begin
      segNext[0] = ZERO_CODE;
      segCnt     = 3'd1;
    end else begin
      if (hunD != 4'd0) begin
        segNext[0] = onesCode(hunD);
        segNext[1] = HUNDRED_CODE;
        segCnt     = 3'd2;
        if (tensD != 4'd0) begin
          segNext[segCnt[1:0]] = tensCode(tensD);
          segCnt               = segCnt + 3'd1;
        end else if (onesD != 4'd0) begin
          segNext[segCnt[1:0]] = ZERO_CODE;
          segCnt               = segCnt + 3'd1;
        end
      end else if (tensD != 4'd0) begin
        segNext[0] = tensCode(tensD);
        segCnt     = 3'd1;
      end
      if (onesD != 4'd0) begin
        segNext[segCnt[1:0]] = onesCode(onesD);
        segCnt               = segCnt + 3'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    bitCnt_d    = bitCnt_q;
    oor_d       = oor_q;
    seg_d       = seg_q;
    segLen_d    = segLen_q;
    idx_d       = idx_q;
    code_d      = code_q;
    codeValid_d = codeValid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d  = value;
          bcd_d    = '0;
          bitCnt_d = '0;
          oor_d    = 32'(value) > MAX_VAL;
          state_d  = CONV;
        end
      end
      CONV: begin
        shift_d  = {shift_q[VAL_W-2:0], 1'b0};
        bcd_d    = bcdShift;
        bitCnt_d = bitCnt_q + CNT_W'(1);
        // The list is registered in the last conversion cycle so the first code follows directly.
        if (bitCnt_q == CNT_W'(VAL_W - 1)) begin
          seg_d       = segNext;
          segLen_d    = segCnt;
          idx_d       = 2'd0;
          code_d      = segNext[0];
          codeValid_d = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (codeValid_q && code_ready) begin
          if ({1'b0, idx_q} + 3'd1 == segLen_q) begin
            codeValid_d = 1'b0;
            code_d      = '0;
            state_d     = FIN;
          end else begin
            idx_d  = idx_q + 2'd1;
            code_d = seg_q[idx_q + 2'd1];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bcd_q       <= '0;
      bitCnt_q    <= '0;
      oor_q       <= 1'b0;
      seg_q       <= '{default: '0};
      segLen_q    <= '0;
      idx_q       <= '0;
      code_q      <= '0;
      codeValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      bitCnt_q    <= bitCnt_d;
      oor_q       <= oor_d;
      seg_q       <= seg_d;
      segLen_q    <= segLen_d;
      idx_q       <= idx_d;
      code_q      <= code_d;
      codeValid_q <= codeValid_d;
    end
  end

  assign busy       = (state_q == CONV) || (state_q == EMIT);
  assign done       = (state_q == FIN);
  assign code       = code_q;
  assign code_valid = codeValid_q;

endmodule

// File: tb/tb_voice_num_sequencer.sv
// Bench for voice_num_sequencer: a cycle-level behavioural model built from decimal
// arithmetic, directed literal cases, randomized values/ready and a reset-abort case.
module tb_voice_num_sequencer;

  localparam int VAL_W = 10;

  logic       clk = 1'b0;
  logic       rst, start, code_ready;
  logic [9:0] value;
  logic       busy, code_valid, done;
  logic [4:0] code;

  logic       start2, codeReady2;
  logic [9:0] value2;
  logic       busy2, codeValid2, done2;
  logic [4:0] code2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  voice_num_sequencer #(.VAL_W(VAL_W), .MAX_DIG(3)) u1 (
    .clk(clk), .rst(rst), .start(start), .value(value), .busy(busy),
    .code(code), .code_valid(code_valid), .code_ready(code_ready), .done(done)
  );

  voice_num_sequencer #(.VAL_W(VAL_W), .MAX_DIG(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .value(value2), .busy(busy2),
    .code(code2), .code_valid(codeValid2), .code_ready(codeReady2), .done(done2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Segment list derived from the decimal digits of the reading.
  function automatic int buildList(input int v, input int maxDig, output logic [4:0] c [4]);
    int h, t, o, n;
    for (int k = 0; k < 4; k++) c[k] = 5'd0;
    if (v > ((maxDig == 3) ? 999 : 99)) begin
      c[0] = 5'd8;
      return 1;
    end
    if (v == 0) begin
      c[0] = 5'd30;
      return 1;
    end
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    n = 0;
    if (h > 0) begin
      c[0] = 5'(30 - h);
      c[1] = 5'd7;
      n = 2;
      if (t > 0) begin
        c[n] = 5'(21 - t);
        n = n + 1;
      end else if (o > 0) begin
        c[n] = 5'd30;
        n = n + 1;
      end
    end else if (t > 0) begin
      c[0] = 5'(21 - t);
      n = 1;
    end
    if (o > 0) begin
      c[n] = 5'(30 - o);
      n = n + 1;
    end
    return n;
  endfunction

  // Cycle model: pending code queue, cycles left before the first code, and the done cycle.
  bit         modelOn = 1'b0;
  bit         mActive = 1'b0;
  bit         mFin = 1'b0;
  bit         wasFin;
  bit         expValid;
  int         mWait = 0;
  int         mN;
  logic [4:0] mList [4];
  logic [4:0] mQ [$];

  always @(negedge clk) begin
    if (modelOn) begin
      expValid = mActive && (mWait == 0) && (mQ.size() > 0);
      checkOutput("busy", 32'(busy), 32'(mActive));
      checkOutput("code_valid", 32'(code_valid), 32'(expValid));
      checkOutput("done", 32'(done), 32'(mFin));
      if (expValid) checkOutput("code", 32'(code), 32'(mQ[0]));
    end
    if (rst) begin
      mActive = 1'b0;
      mFin    = 1'b0;
      mWait   = 0;
      mQ.delete();
      modelOn = 1'b1;
    end else if (modelOn) begin
      wasFin = mFin;
      mFin   = 1'b0;
      if (mActive) begin
        if (mWait > 0) begin
          mWait = mWait - 1;
        end else if (code_ready && mQ.size() > 0) begin
          void'(mQ.pop_front());
          if (mQ.size() == 0) begin
            mActive = 1'b0;
            mFin    = 1'b1;
          end
        end
      end else if (!wasFin && start) begin
        mN = buildList(int'(value), 3, mList);
        for (int k = 0; k < mN; k++) mQ.push_back(mList[k]);
        mActive = 1'b1;
        mWait   = VAL_W;
      end
    end
  end

  // One announcement on u1; optionally toggles ready and pulses start while busy.
  task automatic applyStimulus(input logic [9:0] v, input bit randomReady, output int n,
                               output logic [4:0] got [8], output int firstValid, output bit doneSeen);
    n          = 0;
    firstValid = -1;
    doneSeen   = 1'b0;
    for (int k = 0; k < 8; k++) got[k] = 5'd0;
    start      = 1'b1;
    value      = v;
    code_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < 200 && !doneSeen; cyc++) begin
      @(negedge clk);
      if (code_valid && firstValid < 0) firstValid = cyc;
      if (code_valid && code_ready) begin
        if (n < 8) got[n] = code;
        n = n + 1;
      end
      if (done) doneSeen = 1'b1;
      @(posedge clk);
      #1;
      start      = (randomReady && !doneSeen && busy) ? ($urandom_range(0, 3) == 0) : 1'b0;
      value      = 10'($urandom);
      code_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(doneSeen), 32'd1);
  endtask

  task automatic collect2(input logic [9:0] v, output int n, output logic [4:0] got [4]);
    bit fin = 1'b0;
    n = 0;
    for (int k = 0; k < 4; k++) got[k] = 5'd0;
    start2 = 1'b1;
    value2 = v;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(negedge clk);
      if (codeValid2) begin
        if (n < 4) got[n] = code2;
        n = n + 1;
      end
      if (done2) fin = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
    end
    checkOutput("u2_done_seen", 32'(fin), 32'd1);
  endtask

  int         dirVal [10]     = '{98, 105, 120, 100, 0, 7, 10, 1000, 64, 999};
  int         dirLen [10]     = '{2, 4, 3, 2, 1, 1, 1, 1, 2, 4};
  int         dirCode [10][4] = '{'{12, 22, 0, 0}, '{29, 7, 30, 25}, '{29, 7, 19, 0}, '{29, 7, 0, 0},
                                  '{30, 0, 0, 0}, '{23, 0, 0, 0}, '{20, 0, 0, 0}, '{8, 0, 0, 0},
                                  '{15, 26, 0, 0}, '{21, 7, 12, 21}};
  int         n, fv, expN;
  bit         ds, seen;
  logic [4:0] got [8];
  logic [4:0] got2 [4];
  logic [4:0] expC [4];
  logic [9:0] rv;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    value      = '0;
    code_ready = 1'b0;
    start2     = 1'b0;
    value2     = '0;
    codeReady2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_code", 32'(code), 32'd0);
    checkOutput("reset_valid", 32'(code_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    expN = buildList(105, 3, expC);
    checkOutput("model_105_len", 32'(expN), 32'd4);
    checkOutput("model_105_zero", 32'(expC[2]), 32'd30);
    expN = buildList(150, 2, expC);
    checkOutput("model_150_d2", 32'(expC[0]), 32'd8);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(10'(dirVal[i]), 1'b0, n, got, fv, ds);
      checkOutput($sformatf("dir%0d_len", dirVal[i]), 32'(n), 32'(dirLen[i]));
      checkOutput($sformatf("dir%0d_first_valid", dirVal[i]), 32'(fv), 32'd11);
      for (int k = 0; k < dirLen[i]; k++)
        checkOutput($sformatf("dir%0d_code%0d", dirVal[i], k), 32'(got[k]), 32'(dirCode[i][k]));
    end

    applyStimulus(10'd98, 1'b1, n, got, fv, ds);
    checkOutput("rr98_len", 32'(n), 32'd2);
    checkOutput("rr98_code0", 32'(got[0]), 32'd12);
    checkOutput("rr98_code1", 32'(got[1]), 32'd22);

    for (int i = 0; i < 25; i++) begin
      rv = (i % 5 == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 1023));
      applyStimulus(rv, 1'b1, n, got, fv, ds);
      expN = buildList(int'(rv), 3, expC);
      checkOutput($sformatf("rnd%0d_len", rv), 32'(n), 32'(expN));
      for (int k = 0; k < expN && k < 4; k++)
        checkOutput($sformatf("rnd%0d_code%0d", rv, k), 32'(got[k]), 32'(expC[k]));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    start      = 1'b1;
    value      = 10'd105;
    code_ready = 1'b1;
    seen       = 1'b0;
    for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
      @(negedge clk);
      if (code_valid && code_ready) seen = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    checkOutput("abort_first_xfer", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_valid_before", 32'(code_valid), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_valid", 32'(code_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (15) begin
      @(negedge clk);
      checkOutput("abort_no_done", 32'(done), 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(10'd64, 1'b0, n, got, fv, ds);
    checkOutput("after_abort_len", 32'(n), 32'd2);
    checkOutput("after_abort_code0", 32'(got[0]), 32'd15);
    checkOutput("after_abort_code1", 32'(got[1]), 32'd26);

    collect2(10'd150, n, got2);
    checkOutput("d2_150_len", 32'(n), 32'd1);
    checkOutput("d2_150_code", 32'(got2[0]), 32'd8);
    collect2(10'd99, n, got2);
    checkOutput("d2_99_len", 32'(n), 32'd2);
    checkOutput("d2_99_code0", 32'(got2[0]), 32'd12);
    checkOutput("d2_99_code1", 32'(got2[1]), 32'd21);
    collect2(10'd1023, n, got2);
    checkOutput("d2_1023_len", 32'(n), 32'd1);
    checkOutput("d2_1023_code", 32'(got2[0]), 32'd8);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
